// File: rtl/seg7_pkg.sv
// Shared types and hex-to-segment glyph lookup for the seg7 scan driver.
// Glyphs are active-high {g,f,e,d,c,b,a}; the driver inverts them for the pins.
package seg7_pkg;

   typedef logic [6:0] seg7_t;

   localparam seg7_t GLYPH_BLANK = 7'h00;

   function automatic seg7_t hex_glyph(input logic [3:0] nib);
      seg7_t g;
      case (nib)
         4'h0:    g = 7'h3F;
         4'h1:    g = 7'h06;
         4'h2:    g = 7'h5B;
         4'h3:    g = 7'h4F;
         4'h4:    g = 7'h66;
         4'h5:    g = 7'h6D;
         4'h6:    g = 7'h7D;
         4'h7:    g = 7'h07;
         4'h8:    g = 7'h7F;
         4'h9:    g = 7'h67;
         4'hA:    g = 7'h77;
         4'hB:    g = 7'h7C;
         4'hC:    g = 7'h39;
         4'hD:    g = 7'h5E;
         4'hE:    g = 7'h79;
         4'hF:    g = 7'h71;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Refresh-slot prescaler: terminal-count pulse every REFRESH_DIV clocks plus a 4-bit sub-phase.
// With SEG7_DIM_EN the slot is built from 16 sub-phases of REFRESH_DIV/16 clocks each.
module seg7_prescaler #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       o_tc,
   output logic [3:0] o_phase
);

`ifdef SEG7_DIM_EN
   localparam int SUB_DIV = REFRESH_DIV / 16;
   localparam int SUB_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);

   logic [SUB_W-1:0] r_sub;
   logic [3:0]       r_phase;
   logic             w_sub_tc;

   assign w_sub_tc = (r_sub == SUB_LAST);

   // Two-level count: r_sub within a sub-phase, r_phase across the 16 sub-phases of a slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sub   <= '0;
         r_phase <= 4'h0;
      end else if (w_sub_tc) begin
         r_sub   <= '0;
         r_phase <= r_phase + 4'h1;
      end else begin
         r_sub   <= r_sub + SUB_W'(1);
      end
   end

   assign o_phase = r_phase;
   assign o_tc    = w_sub_tc && (r_phase == 4'hF);
`else
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   // Plain slot counter, 0..REFRESH_DIV-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_phase = 4'hF;
   assign o_tc    = (r_cnt == CNT_LAST);
`endif

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode hex driver with shadow/display double buffering.
// Define SEG7_DIM_EN to enable 16-step PWM dimming of anode and decimal point.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [3:0]              brightness,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic                    w_tc;
   logic [3:0]              w_phase;
   logic                    w_frame_end;

   logic [IDX_W-1:0]        r_idx;
   logic [4*NUM_DIGITS-1:0] r_sh_data, r_ds_data;
   logic [NUM_DIGITS-1:0]   r_sh_dp, r_ds_dp;
   logic [NUM_DIGITS-1:0]   r_sh_en, r_ds_en;

   logic [NUM_DIGITS-1:0]   r_an;
   logic [6:0]              r_seg;
   logic                    r_dp;
   logic                    r_frame_done;

   logic                    w_digit_on;
   logic                    w_lit;
   logic [3:0]              w_nib;
   logic [NUM_DIGITS-1:0]   w_an_n;
   logic [6:0]              w_seg_n;
   logic                    w_dp_n;

   seg7_prescaler #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_prescaler (
      .clk     (clk),
      .rst_n   (rst_n),
      .o_tc    (w_tc),
      .o_phase (w_phase)
   );

`ifndef SEG7_DIM_EN
   logic w_unused_dim;
   assign w_unused_dim = ^{brightness, w_phase};
`endif

   assign w_frame_end = w_tc && (r_idx == LAST_IDX);

   // Next-output decode for the digit currently selected by r_idx.
   always_comb begin
      w_an_n     = '1;
      w_digit_on = r_ds_en[r_idx];
      w_nib      = r_ds_data[{r_idx, 2'b00} +: 4];
`ifdef SEG7_DIM_EN
      w_lit      = w_digit_on && (w_phase <= brightness);
`else
      w_lit      = w_digit_on;
`endif
      w_an_n[r_idx] = ~w_lit;
      if (w_digit_on) begin
         w_seg_n = ~hex_glyph(w_nib);
      end else begin
         w_seg_n = ~GLYPH_BLANK;
      end
      w_dp_n = ~(r_ds_dp[r_idx] & w_lit);
   end

   // Shadow capture, frame-synchronous display update, scan index and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx        <= '0;
         r_sh_data    <= '0;
         r_sh_dp      <= '0;
         r_sh_en      <= '0;
         r_ds_data    <= '0;
         r_ds_dp      <= '0;
         r_ds_en      <= '0;
         r_an         <= '1;
         r_seg        <= 7'h7F;
         r_dp         <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         if (load) begin
            r_sh_data <= data;
            r_sh_dp   <= dp_in;
            r_sh_en   <= digit_en;
         end
         // The display copies the pre-edge shadow, so a coincident load waits a frame.
         if (w_frame_end) begin
            r_ds_data <= r_sh_data;
            r_ds_dp   <= r_sh_dp;
            r_ds_en   <= r_sh_en;
         end
         if (w_tc) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
         end
         r_frame_done <= w_frame_end;
         r_an         <= w_an_n;
         r_seg        <= w_seg_n;
         r_dp         <= w_dp_n;
      end
   end

   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = r_dp;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4, REFRESH_DIV=16):
// table vectors, tear-free/reset sequences and random loads against a cycle-arithmetic model.
module tb_seg7_scan_driver;

   localparam int ND    = 4;
   localparam int RD    = 16;
   localparam int FRAME = ND * RD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [15:0] data;
   logic [3:0]  dp_in, digit_en, brightness;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp, frame_done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .data       (data),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .brightness (brightness),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_done (frame_done)
   );

   logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model: edges since reset, what is latched for the next frame, what is on show.
   int          edge_cnt;
   logic [15:0] m_sh_data, m_ds_data;
   logic [3:0]  m_sh_dp, m_ds_dp, m_sh_en, m_ds_en;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp, e_fd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic model_reset();
      edge_cnt  = 0;
      m_sh_data = '0; m_ds_data = '0;
      m_sh_dp   = '0; m_ds_dp   = '0;
      m_sh_en   = '0; m_ds_en   = '0;
   endtask

   task automatic model_edge();
      int   p, dig;
      logic on, lit;
      edge_cnt++;
      p   = edge_cnt - 1;
      dig = (p / RD) % ND;
      on  = m_ds_en[dig];
      lit = on;
`ifdef SEG7_DIM_EN
      lit = on && ((p % RD) <= int'(brightness));
`endif
      e_an = 4'hF;
      if (lit) e_an[dig] = 1'b0;
      e_seg = on ? ~glyph_tbl[m_ds_data[dig*4 +: 4]] : 7'h7F;
      e_dp  = ~(lit && m_ds_dp[dig]);
      e_fd  = (edge_cnt % FRAME) == 0;
      if (e_fd) begin
         m_ds_data = m_sh_data; m_ds_dp = m_sh_dp; m_ds_en = m_sh_en;
      end
      if (load) begin
         m_sh_data = data; m_sh_dp = dp_in; m_sh_en = digit_en;
      end
   endtask

   task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] env);
      load = ld; data = d; dp_in = dpv; digit_en = env;
      @(posedge clk);
      model_edge();
      #1;
      check("model_an", 32'(an), 32'(e_an));
      check("model_seg", 32'(seg), 32'(e_seg));
      check("model_dp", 32'(dp), 32'(e_dp));
      check("model_frame_done", 32'(frame_done), 32'(e_fd));
      check("one_hot_anode", 32'($countones(~an) <= 1), 32'd1);
      load = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, data, dp_in, digit_en);
   endtask

   // Step until the edge counter hits the given position within a frame (always 1..FRAME steps).
   task automatic run_to(input int pos);
      int guard = 0;
      do begin
         idle(1);
         guard++;
      end while ((edge_cnt % FRAME) != pos && guard < FRAME);
   endtask

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  en;
      logic [3:0]  dpin;
      logic [15:0] exp_an;   // digit3..digit0
      logic [27:0] exp_seg;  // digit3..digit0
      logic [3:0]  exp_dp;   // digit3..digit0
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{16'h1A2F, 4'hF, 4'h0, 16'h7BDE, {7'h79, 7'h08, 7'h24, 7'h0E}, 4'hF};
      vecs[1] = '{16'h1A2F, 4'b0101, 4'b0001, 16'hFBFE, {7'h7F, 7'h08, 7'h7F, 7'h0E}, 4'hE};
      vecs[2] = '{16'h3210, 4'hF, 4'b1010, 16'h7BDE, {7'h30, 7'h24, 7'h79, 7'h40}, 4'h5};
      vecs[3] = '{16'h7654, 4'hF, 4'h0, 16'h7BDE, {7'h78, 7'h02, 7'h12, 7'h19}, 4'hF};
      vecs[4] = '{16'hBA98, 4'hF, 4'h0, 16'h7BDE, {7'h03, 7'h08, 7'h18, 7'h00}, 4'hF};
      vecs[5] = '{16'hFEDC, 4'b1110, 4'hF, 16'h7BDF, {7'h0E, 7'h06, 7'h21, 7'h7F}, 4'h1};

      rst_n = 1'b0; load = 1'b0; data = '0; dp_in = '0; digit_en = '0; brightness = 4'hF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_an", 32'(an), 32'h0000_000F);
      check("reset_seg", 32'(seg), 32'h0000_007F);
      check("reset_dp", 32'(dp), 32'd1);
      check("reset_frame_done", 32'(frame_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors: load, wait for the next frame boundary, then sample mid-slot per digit.
      for (int v = 0; v < 6; v++) begin
         int ld_edge, guard;
         step(1'b1, vecs[v].data, vecs[v].dpin, vecs[v].en);
         ld_edge = edge_cnt;
         guard = 0;
         while (!((edge_cnt % FRAME) == 0 && edge_cnt > ld_edge) && guard < 2 * FRAME) begin
            idle(1);
            guard++;
         end
         check("vec_boundary_frame_done", 32'(frame_done), 32'd1);
         idle(8);
         for (int d = 0; d < ND; d++) begin
            check("vec_an", 32'(an), 32'(vecs[v].exp_an[d*4 +: 4]));
            check("vec_seg", 32'(seg), 32'(vecs[v].exp_seg[d*7 +: 7]));
            check("vec_dp", 32'(dp), 32'(vecs[v].exp_dp[d]));
            idle(RD);
         end
      end

      // Tear-free: a load during slot 1 must not disturb the rest of the frame.
      step(1'b1, 16'h1A2F, 4'h0, 4'hF);
      run_to(0);
      run_to(20);
      step(1'b1, 16'h0000, 4'h0, 4'hF);
      run_to(40);
      check("tear_old_digit2", 32'(seg), 32'h0000_0008);
      run_to(0);
      idle(8);
      check("tear_new_digit0", 32'(seg), 32'h0000_0040);
      // A load on the boundary edge itself is deferred one frame.
      run_to(FRAME - 1);
      step(1'b1, 16'h8888, 4'h0, 4'hF);
      check("coincident_frame_done", 32'(frame_done), 32'd1);
      idle(8);
      check("coincident_deferred", 32'(seg), 32'h0000_0040);
      run_to(0);
      idle(8);
      check("coincident_applied", 32'(seg), 32'h0000_0000);

      // Random loads and brightness against the model.
      for (int n = 0; n < 10000; n++) begin
         brightness = 4'($urandom_range(0, 15));
         step(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), 4'($urandom));
      end

      // Asynchronous reset mid-slot while a digit is lit.
      brightness = 4'hF;
      step(1'b1, 16'h1A2F, 4'hF, 4'hF);
      run_to(0);
      run_to(5);
      check("prereset_lit", 32'(an), 32'h0000_000E);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_an", 32'(an), 32'h0000_000F);
      check("async_reset_seg", 32'(seg), 32'h0000_007F);
      check("async_reset_dp", 32'(dp), 32'd1);
      check("async_reset_frame_done", 32'(frame_done), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(1'b1, 16'h1A2F, 4'h0, 4'hF);
      run_to(0);
      idle(8);
      check("restart_idx0_an", 32'(an), 32'h0000_000E);
      check("restart_idx0_seg", 32'(seg), 32'h0000_000E);

`ifdef SEG7_DIM_EN
      for (int b = 0; b < 2; b++) begin
         int lows = 0;
         brightness = (b == 0) ? 4'd3 : 4'd15;
         run_to(0);
         for (int k = 0; k < RD; k++) begin
            idle(1);
            if (an[0] == 1'b0) lows++;
         end
         check("dim_low_cycles", 32'(lows), (b == 0) ? 32'd4 : 32'd16);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
